// File: rtl/arp_rx_parser_w.sv
// ARP receive parser: captures the first 42 bytes of each frame from a byte-lane stream,
// checks it is an ARP request/reply for this host, and presents the fields on a valid/ready port.
module arp_rx_parser_w #(
    parameter int DATA_BYTES   = 1,
    parameter int ACCEPT_REPLY = 1,
    parameter int ALLOW_BCAST  = 1,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [47:0]             hw_addr_i,
    input  logic [31:0]             ip_addr_i,
    input  logic [8*DATA_BYTES-1:0] s_data_i,
    input  logic [DATA_BYTES-1:0]   s_keep_i,
    input  logic                    s_valid_i,
    input  logic                    s_last_i,
    output logic [15:0]             arp_oper_o,
    output logic [47:0]             arp_sha_o,
    output logic [31:0]             arp_spa_o,
    output logic [47:0]             arp_tha_o,
    output logic [31:0]             arp_tpa_o,
    output logic                    arp_valid_o,
    input  logic                    arp_ready_i,
    output logic [CNT_W-1:0]        ok_cnt_o,
    output logic [CNT_W-1:0]        drop_cnt_o,
    output logic [CNT_W-1:0]        ovf_cnt_o,
    output logic [1:0]              dbg_state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, SKIP = 2'd2, EVAL = 2'd3} state_t;
    localparam int HDR_BYTES = 42;

    state_t     state_q, state_d;
    logic [5:0] off_q, len_q, off_next;
    logic [6:0] nbytes, sum;
    logic [6:0] lane_off [DATA_BYTES];
    logic [7:0] cap_q [HDR_BYTES];

    // Keep is contiguous from lane 0, so lane i lands at offset off_q + i.
    always_comb begin
        nbytes = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            nbytes      = nbytes + 7'(s_keep_i[i]);
            lane_off[i] = 7'(off_q) + 7'(i);
        end
        sum      = 7'(off_q) + nbytes;
        off_next = (sum > 7'd63) ? 6'd63 : sum[5:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s_valid_i) state_d = s_last_i ? EVAL : CAPTURE;
            CAPTURE: if (s_valid_i) begin
                         if (s_last_i)                      state_d = EVAL;
                         else if (sum >= 7'(HDR_BYTES))     state_d = SKIP;
                     end
            SKIP:    if (s_valid_i && s_last_i) state_d = EVAL;
            EVAL:    if (s_valid_i) state_d = s_last_i ? EVAL : CAPTURE;
                     else           state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign dbg_state_o = state_q;

    logic [47:0] f_dst, f_sha, f_tha;
    logic [15:0] f_etype, f_htype, f_ptype, f_oper;
    logic [31:0] f_spa, f_tpa;
    logic        dst_ok, oper_ok, accept, out_free;

    assign f_dst   = {cap_q[0], cap_q[1], cap_q[2], cap_q[3], cap_q[4], cap_q[5]};
    assign f_etype = {cap_q[12], cap_q[13]};
    assign f_htype = {cap_q[14], cap_q[15]};
    assign f_ptype = {cap_q[16], cap_q[17]};
    assign f_oper  = {cap_q[20], cap_q[21]};
    assign f_sha   = {cap_q[22], cap_q[23], cap_q[24], cap_q[25], cap_q[26], cap_q[27]};
    assign f_spa   = {cap_q[28], cap_q[29], cap_q[30], cap_q[31]};
    assign f_tha   = {cap_q[32], cap_q[33], cap_q[34], cap_q[35], cap_q[36], cap_q[37]};
    assign f_tpa   = {cap_q[38], cap_q[39], cap_q[40], cap_q[41]};

    assign dst_ok  = (f_dst == hw_addr_i) || ((ALLOW_BCAST != 0) && (f_dst == 48'hffff_ffff_ffff));
    assign oper_ok = (f_oper == 16'd1) || ((ACCEPT_REPLY != 0) && (f_oper == 16'd2));
    assign accept  = (len_q >= 6'(HDR_BYTES)) && dst_ok && (f_etype == 16'h0806) &&
                     (f_htype == 16'd1) && (f_ptype == 16'h0800) && (cap_q[18] == 8'd6) &&
                     (cap_q[19] == 8'd4) && oper_ok && (f_tpa == ip_addr_i);

    // Output handshake: a record transfers on a cycle with arp_valid_o && arp_ready_i; while
    // valid is high without ready the record is frozen, and the slot counts as free on transfer.
    assign out_free = !arp_valid_o || arp_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            off_q       <= '0;
            len_q       <= '0;
            for (int j = 0; j < HDR_BYTES; j++) cap_q[j] <= '0;
            arp_valid_o <= 1'b0;
            arp_oper_o  <= '0;
            arp_sha_o   <= '0;
            arp_spa_o   <= '0;
            arp_tha_o   <= '0;
            arp_tpa_o   <= '0;
            ok_cnt_o    <= '0;
            drop_cnt_o  <= '0;
            ovf_cnt_o   <= '0;
        end else begin
            state_q <= state_d;
            if (s_valid_i) begin
                off_q <= s_last_i ? '0 : off_next;
                if (s_last_i) len_q <= off_next;
                for (int j = 0; j < HDR_BYTES; j++)
                    for (int i = 0; i < DATA_BYTES; i++)
                        if (s_keep_i[i] && (lane_off[i] == 7'(j))) cap_q[j] <= s_data_i[8*i +: 8];
            end
            if (arp_valid_o && arp_ready_i) arp_valid_o <= 1'b0;
            if (state_q == EVAL) begin
                if (accept) begin
                    if (ok_cnt_o != '1) ok_cnt_o <= ok_cnt_o + CNT_W'(1);
                    if (out_free) begin
                        arp_valid_o <= 1'b1;
                        arp_oper_o  <= f_oper;
                        arp_sha_o   <= f_sha;
                        arp_spa_o   <= f_spa;
                        arp_tha_o   <= f_tha;
                        arp_tpa_o   <= f_tpa;
                    end else if (ovf_cnt_o != '1) begin
                        ovf_cnt_o <= ovf_cnt_o + CNT_W'(1);
                    end
                end else if (drop_cnt_o != '1) begin
                    drop_cnt_o <= drop_cnt_o + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_arp_rx_parser_w.sv
// Bench for arp_rx_parser_w: byte-wide, 4-byte-wide and request-only instances fed directed
// ARP frames; a tagged expected queue is popped on every output handshake.
`timescale 1ns/1ps
module tb_arp_rx_parser_w;
    localparam logic [47:0] HW   = 48'h02_00_00_00_00_01;
    localparam logic [31:0] IP   = 32'hc0a8_0001;
    localparam logic [47:0] BC   = 48'hffff_ffff_ffff;
    localparam logic [47:0] SHA  = 48'h02_11_22_33_44_55;
    localparam logic [31:0] SPA  = 32'hc0a8_0002;
    localparam logic [47:0] SHA2 = 48'h02_aa_bb_cc_dd_ee;
    localparam logic [31:0] SPA2 = 32'hc0a8_0009;
    localparam logic [47:0] THA  = 48'h00_00_5e_00_53_01;
    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data [NI];
    logic [3:0]  s_keep [NI];
    logic        s_valid [NI];
    logic        s_last [NI];
    logic        arp_ready [NI];
    logic        arp_valid [NI];
    logic [15:0] arp_oper [NI];
    logic [47:0] arp_sha [NI];
    logic [31:0] arp_spa [NI];
    logic [47:0] arp_tha [NI];
    logic [31:0] arp_tpa [NI];
    logic [15:0] ok_cnt [NI];
    logic [15:0] drop_cnt [NI];
    logic [15:0] ovf_cnt [NI];
    logic [1:0]  dbg_state [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DB = (g == 1) ? 4 : 1;
        localparam int AR = (g == 2) ? 0 : 1;
        arp_rx_parser_w #(.DATA_BYTES(DB), .ACCEPT_REPLY(AR), .ALLOW_BCAST(1), .CNT_W(16)) u_dut (
            .clk(clk), .rst(rst), .hw_addr_i(HW), .ip_addr_i(IP),
            .s_data_i(s_data[g][8*DB-1:0]), .s_keep_i(s_keep[g][DB-1:0]),
            .s_valid_i(s_valid[g]), .s_last_i(s_last[g]),
            .arp_oper_o(arp_oper[g]), .arp_sha_o(arp_sha[g]), .arp_spa_o(arp_spa[g]),
            .arp_tha_o(arp_tha[g]), .arp_tpa_o(arp_tpa[g]),
            .arp_valid_o(arp_valid[g]), .arp_ready_i(arp_ready[g]),
            .ok_cnt_o(ok_cnt[g]), .drop_cnt_o(drop_cnt[g]), .ovf_cnt_o(ovf_cnt[g]),
            .dbg_state_o(dbg_state[g])
        );
    end

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt [NI];
    int hs_before;
    logic [177:0] exp_q [$];
    logic [7:0]   frm [64];
    int           frm_len;

    function automatic logic [175:0] exp_fields(input logic [15:0] op, input logic [47:0] sha,
                                                input logic [31:0] spa, input logic [31:0] tpa);
        return {op, sha, spa, THA, tpa};
    endfunction

    function automatic logic [175:0] dut_fields(input int k);
        return {arp_oper[k], arp_sha[k], arp_spa[k], arp_tha[k], arp_tpa[k]};
    endfunction

    task automatic check(input string name, input logic [175:0] act, input logic [175:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string name, input int k, input int ok, input int drop, input int ovf);
        check(name, 176'({ok_cnt[k], drop_cnt[k], ovf_cnt[k]}), 176'({16'(ok), 16'(drop), 16'(ovf)}));
    endtask

    task automatic build(input logic [15:0] op, input logic [47:0] dst, input logic [15:0] etype,
                         input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa,
                         input int len);
        logic [47:0] tha;
        tha = THA;
        for (int i = 0; i < 64; i++) frm[i] = 8'ha5;
        for (int i = 0; i < 6; i++) begin
            frm[i]      = dst[47-8*i -: 8];
            frm[6+i]    = sha[47-8*i -: 8];
            frm[22+i]   = sha[47-8*i -: 8];
            frm[32+i]   = tha[47-8*i -: 8];
        end
        frm[12] = etype[15:8]; frm[13] = etype[7:0];
        frm[14] = 8'h00; frm[15] = 8'h01; frm[16] = 8'h08; frm[17] = 8'h00;
        frm[18] = 8'h06; frm[19] = 8'h04;
        frm[20] = op[15:8];    frm[21] = op[7:0];
        for (int i = 0; i < 4; i++) begin
            frm[28+i] = spa[31-8*i -: 8];
            frm[38+i] = tpa[31-8*i -: 8];
        end
        frm_len = len;
    endtask

    task automatic idle(input int k, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            s_valid[k] = 1'b0;
            s_last[k]  = 1'b0;
        end
    endtask

    task automatic send1(input int k, input int gap_at, input int gap_len, input int rst_at);
        for (int b = 0; b < frm_len; b++) begin
            if (b == gap_at) idle(k, gap_len);
            @(negedge clk);
            s_valid[k] = 1'b1;
            s_keep[k]  = 4'h1;
            s_data[k]  = {24'h0, frm[b]};
            s_last[k]  = (b == frm_len - 1);
            if (b == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst        = 1'b0;
                s_valid[k] = 1'b0;
                s_last[k]  = 1'b0;
                return;
            end
        end
    endtask

    task automatic send4(input int k, input int gap_beat, input int gap_len);
        int nb;
        nb = (frm_len + 3) / 4;
        for (int t = 0; t < nb; t++) begin
            if (t == gap_beat) idle(k, gap_len);
            @(negedge clk);
            s_valid[k] = 1'b1;
            s_last[k]  = (t == nb - 1);
            s_data[k]  = '0;
            s_keep[k]  = '0;
            for (int i = 0; i < 4; i++)
                if (4*t + i < frm_len) begin
                    s_data[k][8*i +: 8] = frm[4*t + i];
                    s_keep[k][i]        = 1'b1;
                end
        end
    endtask

    always @(negedge clk) begin
        logic [177:0] e;
        if (!rst) begin
            for (int k = 0; k < NI; k++) begin
                if (arp_valid[k] && arp_ready[k]) begin
                    hs_cnt[k]++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_out inst %0d: got %h expected none", k, dut_fields(k));
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("out_inst%0d", k), {2'(k), dut_fields(k)}, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            s_valid[k] = 1'b0; s_last[k] = 1'b0; s_keep[k] = '0; s_data[k] = '0;
            arp_ready[k] = 1'b1;
            hs_cnt[k] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_valid_%0d", k), 176'(arp_valid[k]), 176'(0));
            check($sformatf("rst_fields_%0d", k), dut_fields(k), 176'(0));
            chk_cnt($sformatf("rst_cnt_%0d", k), k, 0, 0, 0);
            check($sformatf("rst_state_%0d", k), 176'(dbg_state[k]), 176'(0));
        end

        // 60-byte broadcast request, byte lanes; exact output latency
        build(16'd1, BC, 16'h0806, SHA, SPA, IP, 60);
        exp_q.push_back({2'd0, exp_fields(16'd1, SHA, SPA, IP)});
        send1(0, -1, 0, -1);
        idle(0, 1);
        check("t1_eval_state", 176'(dbg_state[0]), 176'(3));
        check("t1_valid_early", 176'(arp_valid[0]), 176'(0));
        @(negedge clk);
        check("t1_valid_on", 176'(arp_valid[0]), 176'(1));
        check("t1_oper", 176'(arp_oper[0]), 176'(16'h0001));
        @(negedge clk);
        check("t1_valid_off", 176'(arp_valid[0]), 176'(0));
        chk_cnt("t1_cnt", 0, 1, 0, 0);

        // 42 bytes over 4-byte lanes, gap mid-frame, final keep 0011
        build(16'd1, BC, 16'h0806, SHA, SPA, IP, 42);
        exp_q.push_back({2'd1, exp_fields(16'd1, SHA, SPA, IP)});
        send4(1, 5, 3);
        idle(1, 4);
        chk_cnt("t2_cnt", 1, 1, 0, 0);

        // short frame, IPv4 ethertype, wrong tpa: all dropped
        build(16'd1, BC, 16'h0806, SHA, SPA, IP, 41);
        send1(0, -1, 0, -1); idle(0, 3);
        build(16'd1, BC, 16'h0800, SHA, SPA, IP, 60);
        send1(0, -1, 0, -1); idle(0, 3);
        build(16'd1, BC, 16'h0806, SHA, SPA, 32'hc0a8_0063, 60);
        send1(0, -1, 0, -1); idle(0, 3);
        chk_cnt("t3_cnt", 0, 1, 3, 0);

        // unicast to our MAC accepted, unicast to another MAC dropped
        build(16'd1, HW, 16'h0806, SHA, SPA, IP, 60);
        exp_q.push_back({2'd0, exp_fields(16'd1, SHA, SPA, IP)});
        send1(0, 10, 2, -1); idle(0, 4);
        build(16'd1, 48'h02_00_00_00_00_99, 16'h0806, SHA, SPA, IP, 60);
        send1(0, -1, 0, -1); idle(0, 3);
        chk_cnt("t3b_cnt", 0, 2, 4, 0);

        // request-only instance: reply dropped, request accepted
        build(16'd2, BC, 16'h0806, SHA, SPA, IP, 60);
        send1(2, -1, 0, -1); idle(2, 3);
        chk_cnt("t4_reply_drop", 2, 0, 1, 0);
        build(16'd1, BC, 16'h0806, SHA2, SPA2, IP, 60);
        exp_q.push_back({2'd2, exp_fields(16'd1, SHA2, SPA2, IP)});
        send1(2, -1, 0, -1); idle(2, 4);
        chk_cnt("t4_req_ok", 2, 1, 1, 0);

        // output stalled: back-to-back accepted frames, second overflows
        arp_ready[0] = 1'b0;
        build(16'd1, BC, 16'h0806, SHA, SPA, IP, 60);
        exp_q.push_back({2'd0, exp_fields(16'd1, SHA, SPA, IP)});
        send1(0, -1, 0, -1);
        build(16'd2, HW, 16'h0806, SHA2, SPA2, IP, 60);
        send1(0, -1, 0, -1);
        idle(0, 4);
        check("t5_hold_valid", 176'(arp_valid[0]), 176'(1));
        check("t5_hold_fields", dut_fields(0), exp_fields(16'd1, SHA, SPA, IP));
        chk_cnt("t5_cnt", 0, 4, 4, 1);
        hs_before = hs_cnt[0];
        arp_ready[0] = 1'b1;
        idle(0, 4);
        check("t5_one_hs", 176'(hs_cnt[0] - hs_before), 176'(1));
        check("t5_drained", 176'(arp_valid[0]), 176'(0));

        // reset at byte 20, then a clean frame
        build(16'd1, BC, 16'h0806, SHA, SPA, IP, 60);
        send1(0, -1, 0, 20);
        idle(0, 2);
        chk_cnt("t6_after_rst", 0, 0, 0, 0);
        check("t6_rst_state", 176'(dbg_state[0]), 176'(0));
        build(16'd1, BC, 16'h0806, SHA2, SPA2, IP, 60);
        exp_q.push_back({2'd0, exp_fields(16'd1, SHA2, SPA2, IP)});
        hs_before = hs_cnt[0];
        send1(0, -1, 0, -1);
        idle(0, 4);
        check("t6_one_hs", 176'(hs_cnt[0] - hs_before), 176'(1));
        chk_cnt("t6_cnt", 0, 1, 0, 0);

        repeat (5) @(negedge clk);
        check("queue_empty", 176'(exp_q.size()), 176'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
